// File: rtl/dm_pipe_if.sv
// Request/response bundle for dm_pipe: valid/ready request port plus valid/ready response port.
// The master drives requests and accepts responses; dm_pipe sits on the slave modport.
interface dm_pipe_if #(
    parameter int ADDR_W = 12
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [31:0]       req_pc;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_pc, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_pc, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dm_pipe.sv
// Data memory with byte/halfword/word alignment, sign/zero extension and configurable read latency.
// Optional store trace printing is enabled with the DM_TRACE_EN macro.
module dm_pipe #(
    parameter int ADDR_W    = 12,
    parameter int RD_LAT    = 1,
    parameter bit INIT_ZERO = 1'b1
) (
    input logic      clk,
    input logic      rst,
    dm_pipe_if.slave bus
);
    localparam int DEPTH = 2 ** (ADDR_W - 2);

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t state;
    logic [1:0] wait_cnt;

    logic [31:0] mem [DEPTH] = '{default: (INIT_ZERO ? 32'h0000_0000 : 32'hxxxx_xxxx)};

    logic [ADDR_W-3:0] word_idx;
    logic [1:0]        byte_off;
    logic              accept;
    logic              req_err;
    logic              commit;
    logic [3:0]        be;
    logic [31:0]       wlanes;
    logic [31:0]       cur_word;
    logic [31:0]       merged;
    logic [7:0]        sel_byte;
    logic [15:0]       sel_half;
    logic [31:0]       load_data;

    assign word_idx      = bus.req_addr[ADDR_W-1:2];
    assign byte_off      = bus.req_addr[1:0];
    assign bus.req_ready = (state == S_IDLE) && !rst;
    assign accept        = bus.req_valid && bus.req_ready;
    assign commit        = accept && bus.req_we && !req_err;
    assign cur_word      = mem[word_idx];

    always_comb begin : align_check
        // NOTE: every always_comb output gets a default first so no latch can be inferred.
        req_err = 1'b0;
        case (bus.req_size)
            SIZE_B:  req_err = 1'b0;
            SIZE_H:  req_err = byte_off[0];
            SIZE_W:  req_err = |byte_off;
            default: req_err = 1'b1;
        endcase
    end

    always_comb begin : store_lanes
        be     = 4'b0000;
        wlanes = bus.req_wdata;
        case (bus.req_size)
            SIZE_B: begin
                be     = 4'b0001 << byte_off;
                wlanes = {4{bus.req_wdata[7:0]}};
            end
            SIZE_H: begin
                be     = byte_off[1] ? 4'b1100 : 4'b0011;
                wlanes = {2{bus.req_wdata[15:0]}};
            end
            SIZE_W:  be = 4'b1111;
            default: be = 4'b0000;
        endcase
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = be[i] ? wlanes[8*i +: 8] : cur_word[8*i +: 8];
        end
    end

    always_comb begin : load_extract
        sel_byte = cur_word[7:0];
        case (byte_off)
            2'd0: sel_byte = cur_word[7:0];
            2'd1: sel_byte = cur_word[15:8];
            2'd2: sel_byte = cur_word[23:16];
            2'd3: sel_byte = cur_word[31:24];
        endcase
        sel_half = byte_off[1] ? cur_word[31:16] : cur_word[15:0];
        case (bus.req_size)
            SIZE_B:  load_data = bus.req_unsigned ? {24'h0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
            SIZE_H:  load_data = bus.req_unsigned ? {16'h0, sel_half} : {{16{sel_half[15]}}, sel_half};
            default: load_data = cur_word;
        endcase
    end

`ifdef DM_TRACE_EN
    logic [31:0] trace_addr;
    assign trace_addr = 32'({word_idx, 2'b00});
`else
    logic unused_pc;
    assign unused_pc = ^bus.req_pc;
`endif

    // NOTE: the storage array has no reset; commit is gated by req_ready, which is low during rst.
    always_ff @(posedge clk) begin : mem_write
        if (commit) begin
            mem[word_idx] <= merged;
`ifdef DM_TRACE_EN
            $display("@%08h: *%08h <= %08h", bus.req_pc, trace_addr, merged);
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin : fsm
        if (rst) begin
            state         <= S_IDLE;
            wait_cnt      <= 2'd0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= 32'h0;
            bus.rsp_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        bus.rsp_err   <= req_err;
                        bus.rsp_rdata <= (bus.req_we || req_err) ? 32'h0 : load_data;
                        if (RD_LAT == 1) begin
                            state         <= S_RESP;
                            bus.rsp_valid <= 1'b1;
                        end else begin
                            state    <= S_WAIT;
                            wait_cnt <= 2'(RD_LAT - 2);
                        end
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == 2'd0) begin
                        state         <= S_RESP;
                        bus.rsp_valid <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                S_RESP: begin
                    // Response payload stays registered until the consumer takes it.
                    if (bus.rsp_ready) begin
                        state         <= S_IDLE;
                        bus.rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    state         <= S_IDLE;
                    bus.rsp_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/dm_pipe.md
Name: dm_pipe

Overview:
Parametrised data memory with a valid/ready request port and a valid/ready response port. It handles the byte, halfword and word load/store alignment logic internally: byte-enables, write-data lane steering, load extraction and sign/zero extension. It replaces the unpipelined word RAM in the MEM stage. Read latency is configurable so the block can model slower memories. Misaligned and invalid accesses are flagged instead of being silently executed.

Parameters:
ADDR_W, 12, byte-address width; depth = 2^(ADDR_W-2) 32-bit words
RD_LAT, 1, cycles from request acceptance to rsp_valid; legal range 1..4
INIT_ZERO, 1, when 1 all words are initialised to 0 at time zero (simulation init, not reset)

Ports:
clk  in  1  clock; all state changes on the rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request this cycle
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 halfword, 10 word, 11 invalid
req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, right-aligned (byte in [7:0], halfword in [15:0])
req_pc  in  32  PC of the issuing instruction, used by the trace feature
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts the response
rsp_rdata  out  32  extended load data; 0 for stores and errors
rsp_err  out  1  misaligned or invalid-size access

Behaviour:
- FSM states: IDLE, WAIT, RESP. One request outstanding at a time.
- req_ready = (state == IDLE) && !rst.
- A request is accepted on a rising edge where req_valid && req_ready.
- Reset values: state IDLE, rsp_valid 0, rsp_rdata 0, rsp_err 0, wait counter 0. Memory contents are not altered by reset.
- Error check at acceptance:
  - size 11 -> error
  - halfword with addr[0] = 1 -> error
  - word with addr[1:0] != 00 -> error
  - An errored request writes nothing, and its response carries rsp_err = 1, rsp_rdata = 0.
- Store commit happens on the acceptance edge.
  - Word index = addr[ADDR_W-1:2].
  - Byte store: BE = 0001 << addr[1:0]; wdata[7:0] is replicated to all lanes.
  - Halfword store: BE = 0011 at addr[1] = 0, or 1100 at addr[1] = 1; wdata[15:0] is replicated to both halves.
  - Word store: BE = 1111.
  - Only enabled bytes change.
- Load sampling happens on the acceptance edge.
  - The word is read from the memory contents before the edge.
  - Lane selection uses addr[1:0].
  - Extension is per req_unsigned; word loads ignore req_unsigned.
- Transitions and latency:
  - On accept: go to RESP if RD_LAT = 1; otherwise go to WAIT with counter = RD_LAT-2.
  - WAIT: decrement the counter each cycle; go to RESP when it is 0.
  - rsp_valid = (state == RESP). It first goes high exactly RD_LAT cycles after the acceptance edge.
  - RESP: rsp_rdata and rsp_err are held stable until an edge with rsp_ready = 1; then go to IDLE.
- Back-to-back operation: the next request may be accepted in the cycle after the response handshake. Peak throughput is 1 request per RD_LAT+1 cycles.
- A store returns a response (an ack) like a load, with rsp_rdata = 0.
- Reset mid-operation:
  - A pending response is dropped; rsp_valid is 0 in the cycle after the reset edge.
  - A store already committed on its acceptance edge stays in memory.
  - A request presented in the same cycle as rst is not accepted.
- Addresses wrap within 2^ADDR_W bytes; upper req_addr bits do not exist.

Optional Feature:
DM_TRACE_EN
- Defined: on every committed (non-error) store, at the commit edge, print "@%08h: *%08h <= %08h". The three fields are req_pc, the word-aligned byte address zero-extended to 32 bits, and the full merged word as stored after the byte-enables are applied.
- Errored stores print nothing.
- Not defined: no $display is emitted and there is no functional difference.

Test Plan:
1. Reset, RD_LAT = 1: SW 0x11223344 @0x10 -> response the next cycle with rsp_err = 0, rsp_rdata = 0. Then LW @0x10 -> rsp_rdata 0x11223344 exactly 1 cycle after acceptance.
2. Starting from word 0x11223344 @0x10:
   - SB 0xAB @0x12 -> word becomes 0x11AB3344.
   - LB @0x12 -> 0xFFFFFFAB; LBU @0x12 -> 0x000000AB.
   - SH 0x8001 @0x12 -> 0x80013344; LH @0x12 -> 0xFFFF8001.
3. Error cases:
   - LH @0x11 -> rsp_err = 1, rsp_rdata = 0.
   - SW 0xDEADBEEF @0x16 -> rsp_err = 1; a following LW @0x14 and LW @0x18 show the memory unchanged.
   - req_size = 11 -> rsp_err = 1.
4. RD_LAT = 3, rsp_ready held low for 4 cycles:
   - rsp_valid rises 3 cycles after acceptance.
   - rsp_rdata is stable while rsp_ready is low.
   - req_ready stays 0 until the cycle after the rsp_ready = 1 handshake.
5. RD_LAT = 3, rst asserted one cycle after acceptance of SW 0x5A5A5A5A @0x20 -> rsp_valid never rises. After reset, LW @0x20 returns 0x5A5A5A5A.
6. DM_TRACE_EN defined, req_pc 0x00003000, SB 0x7F @0x21 over word 0 -> prints "@00003000: *00000020 <= 00007f00". The same bench without the macro prints nothing.
